// File: rtl/fp_shift_ctrl.sv
// Sequencer for the FPU mantissa shift register: ALIGN (right shift + sticky)
// and NORM (left shift by leading-zero count, exponent clamped at 1).
module fp_shift_ctrl #(
  parameter int unsigned MAN_W = 64,
  parameter int unsigned EXP_W = 11,
  localparam int unsigned SH_W = $clog2(MAN_W) + 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_op,
  input  logic [MAN_W-1:0] i_req_man,
  input  logic [EXP_W-1:0] i_req_exp,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [MAN_W-1:0] o_rsp_man,
  output logic [EXP_W-1:0] o_rsp_exp,
  output logic             o_rsp_sticky,
  output logic             o_rsp_zero,
  output logic [MAN_W-1:0] o_sr_d,
  output logic             o_sr_en,
  output logic             o_sr_shift_en,
  output logic             o_sr_shift_right,
  output logic             o_sr_arithmetic,
  output logic             o_sr_right_most_1,
  output logic [SH_W-1:0]  o_sr_shift_n,
  input  logic [MAN_W-1:0] i_sr_q
);

  localparam int unsigned AW = ((EXP_W > SH_W) ? EXP_W : SH_W) + 1;
  localparam logic OP_ALIGN = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sticky;
  logic              r_zero;
  logic [SH_W-1:0]   w_lzc;
  logic [SH_W-1:0]   w_amt;
  logic [EXP_W-1:0]  w_exp;
  logic              w_sticky;
  logic              w_zero;
  logic              w_accept;
  logic              w_load_rsp;
  logic              w_clr_valid;

  assign o_req_ready       = (r_state == S_IDLE);
  assign o_sr_arithmetic   = 1'b0;
  assign o_sr_right_most_1 = 1'b0;
  assign w_accept          = i_req_valid && (r_state == S_IDLE);

  // Leading-zero count: the highest set bit is visited last and wins.
  always_comb begin
    w_lzc = SH_W'(MAN_W);
    for (int i = 0; i < int'(MAN_W); i++) begin
      if (i_req_man[i]) w_lzc = SH_W'(int'(MAN_W) - 1 - i);
    end
  end

  // Shift amount and result side-information for the presented command.
  always_comb begin
    w_amt    = '0;
    w_exp    = '0;
    w_sticky = 1'b0;
    w_zero   = 1'b0;
    if (i_req_op == OP_ALIGN) begin
      if (AW'(i_req_exp) >= AW'(MAN_W)) w_amt = SH_W'(MAN_W);
      else                              w_amt = SH_W'(i_req_exp);
      // Mask of the bits shifted out; a full-width shift masks every bit.
      w_sticky = |(i_req_man & ~({MAN_W{1'b1}} << w_amt));
    end else if (i_req_man == '0) begin
      w_zero = 1'b1;
    end else begin
      if (i_req_exp > EXP_W'(1)) begin
        if (AW'(w_lzc) < AW'(i_req_exp - EXP_W'(1))) w_amt = w_lzc;
        else                                          w_amt = SH_W'(i_req_exp - EXP_W'(1));
      end
      w_exp = i_req_exp - EXP_W'(w_amt);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // Next state plus the shift-register controls, live only on the accept cycle.
  always_comb begin
    w_state_nx       = r_state;
    w_load_rsp       = 1'b0;
    w_clr_valid      = 1'b0;
    o_sr_d           = '0;
    o_sr_en          = 1'b0;
    o_sr_shift_en    = 1'b0;
    o_sr_shift_right = 1'b0;
    o_sr_shift_n     = '0;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_nx       = S_SHIFT;
          o_sr_d           = i_req_man;
          o_sr_en          = 1'b1;
          o_sr_shift_en    = 1'b1;
          o_sr_shift_right = (i_req_op == OP_ALIGN);
          o_sr_shift_n     = w_amt;
        end
      end
      S_SHIFT: begin
        w_state_nx = S_RESP;
        w_load_rsp = 1'b1;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_state_nx  = S_IDLE;
          w_clr_valid = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp    <= '0;
      r_sticky <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_exp    <= w_exp;
      r_sticky <= w_sticky;
      r_zero   <= w_zero;
    end
  end

  // Response registers hold until the consumer handshakes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_man    <= '0;
      o_rsp_exp    <= '0;
      o_rsp_sticky <= 1'b0;
      o_rsp_zero   <= 1'b0;
    end else if (w_load_rsp) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_man    <= i_sr_q;
      o_rsp_exp    <= r_exp;
      o_rsp_sticky <= r_sticky;
      o_rsp_zero   <= r_zero;
    end else if (w_clr_valid) begin
      o_rsp_valid  <= 1'b0;
    end
  end

endmodule
